// File: rtl/fa_serial_addsub.sv
// Digit-serial add/subtract: one DIGIT_WIDTH-bit ripple slice per clock, LSB digit first,
// with a registered inter-digit carry and valid/ready handshakes on both sides.
module fa_serial_addsub #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout,
    output logic                  ovf
);

    localparam int NDIG = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_digit
            $error("fa_serial_addsub: DIGIT_WIDTH must divide DATA_WIDTH");
        end
    endgenerate

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic                   carry;
    logic [DIGIT_WIDTH-1:0] da;
    logic [DIGIT_WIDTH-1:0] db;
    logic [DIGIT_WIDTH-1:0] dsum;
    logic [DIGIT_WIDTH:0]   c;
    logic                   last;

    assign da   = a_q[int'(cnt)*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign db   = b_q[int'(cnt)*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign last = (cnt == CW'(NDIG - 1));
    assign c[0] = carry;

    genvar i;
    generate
        for (i = 0; i < DIGIT_WIDTH; i++) begin : g_fa
            assign dsum[i]  = da[i] ^ db[i] ^ c[i];
            assign c[i+1]   = (da[i] & db[i]) | (c[i] & (da[i] ^ db[i]));
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + ~borrow, so invert once at accept time.
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[int'(cnt)*DIGIT_WIDTH +: DIGIT_WIDTH] <= dsum;
                    carry <= c[DIGIT_WIDTH];
                    if (last) begin
                        state <= DONE;
                        cout  <= c[DIGIT_WIDTH];
                        ovf   <= (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                                 (dsum[DIGIT_WIDTH-1] != a_q[DATA_WIDTH-1]);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_addsub.sv
// Directed and random checks of fa_serial_addsub at NDIG=8 and NDIG=1.
module tb_fa_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        iv0 = 1'b0, or0 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
    logic        ir0, ov0, co0, of0, ir1, ov1, co1, of1;
    logic [31:0] s0, s1;
    logic        sel = 1'b0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fa_serial_addsub #(.DATA_WIDTH(32), .DIGIT_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(or0), .s(s0),
        .cout(co0), .ovf(of0));

    fa_serial_addsub #(.DATA_WIDTH(32), .DIGIT_WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(or1), .s(s1),
        .cout(co1), .ovf(of1));

    wire        c_ir = sel ? ir1 : ir0;
    wire        c_ov = sel ? ov1 : ov0;
    wire [31:0] c_s  = sel ? s1  : s0;
    wire        c_co = sel ? co1 : co0;
    wire        c_of = sel ? of1 : of0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input logic v);
        iv0 = sel ? 1'b0 : v;
        iv1 = sel ? v : 1'b0;
    endtask

    task automatic set_or(input logic v);
        or0 = sel ? 1'b0 : v;
        or1 = sel ? v : 1'b0;
    endtask

    // Accept, wait for result, check latency and values, leave DONE pending (no out_ready).
    task automatic start_wait(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                              input logic ts, input string tag);
        int n;
        a = ta; b = tb_; cin = tc; sub = ts;
        check({tag, " in_ready"}, c_ir, 1);
        set_iv(1'b1);
        tick();
        set_iv(1'b0);
        n = 0;
        while (!c_ov && n < 50) begin
            check({tag, " in_ready busy"}, c_ir, 0);
            tick();
            n++;
        end
        check({tag, " latency"}, n, sel ? 1 : 8);
    endtask

    task automatic finish_op(input string tag);
        set_or(1'b1);
        tick();
        set_or(1'b0);
        check({tag, " out_valid drop"}, c_ov, 0);
        check({tag, " ready again"}, c_ir, 1);
    endtask

    task automatic op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                      input logic ts, input logic [31:0] es, input logic ec,
                      input logic eo, input string tag);
        start_wait(ta, tb_, tc, ts, tag);
        check({tag, " s"}, c_s, es);
        check({tag, " cout"}, c_co, ec);
        check({tag, " ovf"}, c_of, eo);
        finish_op(tag);
    endtask

    task automatic rand_op();
        logic [31:0] ra, rb, rs;
        logic        rc, rsb, eo;
        logic [32:0] sum;
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rsb = 1'($urandom);
        if ($urandom_range(0, 7) == 0) rb = ra;
        if (rsb) sum = {1'b0, ra} - {1'b0, rb} - {32'd0, rc} + 33'h1_0000_0000;
        else     sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
        rs = sum[31:0];
        if (rsb) eo = (ra[31] != rb[31]) && (rs[31] != ra[31]);
        else     eo = (ra[31] == rb[31]) && (rs[31] != ra[31]);
        op(ra, rb, rc, rsb, rs, sum[32], eo, sel ? "rnd1" : "rnd8");
    endtask

    initial begin
        #12;
        check("rst s", s0, 0);
        check("rst out_valid", ov0, 0);
        check("rst in_ready", ir0, 1);
        check("rst cout", co0, 0);
        check("rst ovf", of0, 0);
        rst = 1'b0;
        tick();

        op(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, "add wrap");
        op(32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 0, 0, "sub 5-7");
        op(32'h5, 32'h7, 1, 1, 32'hFFFF_FFFD, 0, 0, "sub 5-7-1");
        op(32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, "add ovf");
        op(32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1, "sub ovf");

        // Backpressure: hold result, ignore in_valid pulses.
        start_wait(32'h0000_00F0, 32'h0000_0010, 0, 0, "bp");
        for (int k = 0; k < 5; k++) begin
            a = 32'hDEAD_BEEF; b = 32'h1234_5678; set_iv(k[0]);
            tick();
            check("bp out_valid", c_ov, 1);
            check("bp s", c_s, 32'h0000_0100);
            check("bp cout", c_co, 0);
            check("bp ovf", c_of, 0);
            check("bp in_ready", c_ir, 0);
        end
        set_iv(1'b1);
        set_or(1'b1);
        tick();
        set_iv(1'b0);
        set_or(1'b0);
        check("bp handshake out_valid", c_ov, 0);
        check("bp no accept in handshake", c_ir, 1);
        tick();
        tick();
        check("bp held s", c_s, 32'h0000_0100);
        check("bp still idle", c_ir, 1);

        // Abort mid-RUN after three digits.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 0; sub = 0;
        set_iv(1'b1);
        tick();
        set_iv(1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("abort out_valid", ov0, 0);
        check("abort in_ready", ir0, 1);
        check("abort s", s0, 0);
        #2 rst = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("abort no pulse", ov0, 0);
        end
        op(32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0, "post abort");

        for (int k = 0; k < 1000; k++) rand_op();

        sel = 1'b1;
        op(32'h0, 32'h0, 1, 0, 32'h1, 0, 0, "ndig1 cin");
        op(32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1, "ndig1 sub ovf");
        for (int k = 0; k < 200; k++) rand_op();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
